// File: rtl/bp_access_scheduler_if.sv
// Bus bundle between the branch-predictor access scheduler and its neighbours:
// IF prediction queries, RoB training updates and the single-ported pattern table.
//   slave  : scheduler side (takes queries/updates, drives the table port)
//   master : environment side (IF, RoB and the table RAM)
interface bp_access_scheduler_if #(
    parameter int unsigned IDX_WIDTH = 6
);
    logic                 query_en;
    logic [31:0]          query_pc;
    logic                 query_ready;
    logic                 data_out_en;
    logic                 data_out;
    logic                 upd_en;
    logic [31:0]          upd_pc;
    logic                 upd_taken;
    logic                 upd_full;
    logic                 tbl_en;
    logic                 tbl_we;
    logic [IDX_WIDTH-1:0] tbl_addr;
    logic [1:0]           tbl_wdata;
    logic [1:0]           tbl_rdata;

    modport slave (
        input  query_en, query_pc, upd_en, upd_pc, upd_taken, tbl_rdata,
        output query_ready, data_out_en, data_out, upd_full,
               tbl_en, tbl_we, tbl_addr, tbl_wdata
    );

    modport master (
        output query_en, query_pc, upd_en, upd_pc, upd_taken, tbl_rdata,
        input  query_ready, data_out_en, data_out, upd_full,
               tbl_en, tbl_we, tbl_addr, tbl_wdata
    );
endinterface

// File: rtl/bp_access_scheduler.sv
// Arbitrates the single-ported 2-bit pattern table between IF prediction
// queries (priority, one per cycle) and buffered RoB training updates, which
// drain as read-modify-write pairs in idle cycles or when the FIFO fills.
// Ports:
//   clk_in  - clock
//   rst_in  - synchronous active-high reset
//   rdy_in  - global ready; low pauses all state and table traffic
//   bus     - query / update / table-port bundle (slave modport)
module bp_access_scheduler #(
    parameter int unsigned IDX_WIDTH  = 6,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    bp_access_scheduler_if.slave  bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = IDX_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        Q_RD = 2'd1,
        U_RD = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ENT_W-1:0]     fifo_q [FIFO_DEPTH];
    logic [ENT_W-1:0]     fifo_d [FIFO_DEPTH];

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [IDX_WIDTH-1:0] qry_idx;
    logic [IDX_WIDTH-1:0] upd_idx;
    logic [IDX_WIDTH-1:0] head_idx;
    logic                 head_taken;
    logic [1:0]           ctr_next;
    logic                 unused_bits;

    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign qry_idx    = bus.query_pc[IDX_WIDTH+1:2];
    assign upd_idx    = bus.upd_pc[IDX_WIDTH+1:2];
    assign head_idx   = fifo_q[head_q][ENT_W-1:1];
    assign head_taken = fifo_q[head_q][0];
    assign unused_bits = ^{bus.query_pc[31:IDX_WIDTH+2], bus.query_pc[1:0],
                           bus.upd_pc[31:IDX_WIDTH+2], bus.upd_pc[1:0], bus.tbl_rdata[0]};

    // Saturating 2-bit counter training of the value just read for the FIFO head.
    always_comb begin
        ctr_next = bus.tbl_rdata;
        if (head_taken) begin
            if (bus.tbl_rdata != 2'd3) ctr_next = bus.tbl_rdata + 2'd1;
        end else begin
            if (bus.tbl_rdata != 2'd0) ctr_next = bus.tbl_rdata - 2'd1;
        end
    end

    // Next-state, FIFO bookkeeping and table-port outputs.
    always_comb begin
        state_d         = state_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        fifo_d          = fifo_q;
        push            = 1'b0;
        pop             = 1'b0;
        bus.query_ready = 1'b0;
        bus.data_out_en = 1'b0;
        bus.data_out    = 1'b0;
        bus.tbl_en      = 1'b0;
        bus.tbl_we      = 1'b0;
        bus.tbl_addr    = '0;
        bus.tbl_wdata   = '0;
        bus.upd_full    = full && !rst_in;

        if (!rst_in && rdy_in) begin
            push = bus.upd_en && !full;
            unique case (state_q)
                IDLE, Q_RD: begin
                    // Prediction for last cycle's query; next issue arbitrated alongside.
                    if (state_q == Q_RD) begin
                        bus.data_out_en = 1'b1;
                        bus.data_out    = bus.tbl_rdata[1];
                    end
                    bus.query_ready = !full;
                    if (full || (!bus.query_en && !empty)) begin
                        bus.tbl_en   = 1'b1;
                        bus.tbl_addr = head_idx;
                        state_d      = U_RD;
                    end else if (bus.query_en) begin
                        bus.tbl_en   = 1'b1;
                        bus.tbl_addr = qry_idx;
                        state_d      = Q_RD;
                    end else begin
                        state_d      = IDLE;
                    end
                end
                U_RD: begin
                    bus.tbl_en    = 1'b1;
                    bus.tbl_we    = 1'b1;
                    bus.tbl_addr  = head_idx;
                    bus.tbl_wdata = ctr_next;
                    pop           = 1'b1;
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase

            if (push) begin
                fifo_d[tail_q] = {upd_idx, bus.upd_taken};
                tail_d         = tail_q + PTR_W'(1);
            end
            if (pop) head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State and FIFO registers; rdy_in low holds everything via the comb defaults.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fifo_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fifo_q  <= fifo_d;
        end
    end
endmodule

// File: tb/tb_bp_access_scheduler.sv
// Self-checking bench for bp_access_scheduler: directed scenarios plus a
// randomized run, all scored against a transaction-level reference model
// (pending-update queue + reference counter table).
module tb_bp_access_scheduler;
    localparam int unsigned IDX_WIDTH  = 6;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TBL_N      = 1 << IDX_WIDTH;

    typedef struct packed {
        logic [IDX_WIDTH-1:0] idx;
        logic                 taken;
    } upd_t;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    bp_access_scheduler_if #(.IDX_WIDTH(IDX_WIDTH)) bus();

    bp_access_scheduler #(.IDX_WIDTH(IDX_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Pattern-table RAM: one-cycle read latency, read data held while idle.
    logic [1:0]           mem [TBL_N];
    logic                 ld_en = 1'b0;
    logic [IDX_WIDTH-1:0] ld_idx = '0;
    logic [1:0]           ld_val = '0;
    always @(posedge clk_in) begin
        if (ld_en) mem[ld_idx] <= ld_val;
        else if (bus.tbl_en) begin
            if (bus.tbl_we) mem[bus.tbl_addr] <= bus.tbl_wdata;
            else            bus.tbl_rdata     <= mem[bus.tbl_addr];
        end
    end

    // Reference model state.
    logic [1:0] ref_tbl [TBL_N];
    upd_t       upd_q [$];
    bit         pend_pred = 1'b0;
    logic       pend_val  = 1'b0;
    bit         in_urd    = 1'b0;
    int         writes_seen = 0;
    int         vectors     = 0;
    int         miscompares = 0;

    function automatic logic [1:0] train(logic [1:0] c, logic t);
        int v;
        v = int'(c) + (t ? 1 : -1);
        if (v < 0) v = 0;
        if (v > 3) v = 3;
        return 2'(v);
    endfunction

    // Scores one cycle against the model, then advances the model past the coming edge.
    task automatic observe();
        bit                   full_b;
        logic [IDX_WIDTH-1:0] qidx;
        logic [IDX_WIDTH-1:0] hidx;
        logic                 htaken;
        logic [1:0]           w;
        upd_t                 e;
        full_b = (upd_q.size() == FIFO_DEPTH);
        qidx   = bus.query_pc[IDX_WIDTH+1:2];
        hidx   = (upd_q.size() != 0) ? upd_q[0].idx : '0;
        htaken = (upd_q.size() != 0) ? upd_q[0].taken : 1'b0;
        if (rst_in) begin
            vectors++;
            if ({bus.upd_full, bus.query_ready, bus.data_out_en, bus.data_out, bus.tbl_en,
                 bus.tbl_we, bus.tbl_addr, bus.tbl_wdata} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: got %b want all zero", {bus.upd_full, bus.query_ready,
                         bus.data_out_en, bus.data_out, bus.tbl_en, bus.tbl_we, bus.tbl_addr, bus.tbl_wdata});
            end
            upd_q.delete();
            pend_pred = 1'b0;
            in_urd    = 1'b0;
        end else begin
            vectors++;
            if (bus.upd_full !== full_b) begin
                miscompares++;
                $display("FAIL upd_full: got %b want %b", bus.upd_full, full_b);
            end
            if (!rdy_in) begin
                vectors++;
                if ({bus.tbl_en, bus.query_ready, bus.data_out_en} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL pause_outputs: got %b want 000",
                             {bus.tbl_en, bus.query_ready, bus.data_out_en});
                end
            end else begin
                vectors++;
                if ({bus.data_out_en, bus.data_out} !== {pend_pred, pend_pred & pend_val}) begin
                    miscompares++;
                    $display("FAIL prediction: got en=%b val=%b want en=%b val=%b",
                             bus.data_out_en, bus.data_out, pend_pred, pend_pred & pend_val);
                end
                pend_pred = 1'b0;
                vectors++;
                if (in_urd) begin
                    w = train(ref_tbl[hidx], htaken);
                    if ({bus.query_ready, bus.tbl_en, bus.tbl_we, bus.tbl_addr, bus.tbl_wdata} !==
                        {3'b011, hidx, w}) begin
                        miscompares++;
                        $display("FAIL update_write: got rdy=%b en=%b we=%b addr=%0d wd=%0d want 0/1/1 addr=%0d wd=%0d",
                                 bus.query_ready, bus.tbl_en, bus.tbl_we, bus.tbl_addr, bus.tbl_wdata, hidx, w);
                    end
                    ref_tbl[hidx] = w;
                    void'(upd_q.pop_front());
                    in_urd = 1'b0;
                    writes_seen++;
                end else begin
                    if (bus.query_ready !== !full_b) begin
                        miscompares++;
                        $display("FAIL query_ready: got %b want %b", bus.query_ready, !full_b);
                    end
                    vectors++;
                    if (full_b || (!bus.query_en && upd_q.size() != 0)) begin
                        if ({bus.tbl_en, bus.tbl_we, bus.tbl_addr} !== {2'b10, hidx}) begin
                            miscompares++;
                            $display("FAIL update_read: got en=%b we=%b addr=%0d want 1/0 addr=%0d",
                                     bus.tbl_en, bus.tbl_we, bus.tbl_addr, hidx);
                        end
                        in_urd = 1'b1;
                    end else if (bus.query_en) begin
                        if ({bus.tbl_en, bus.tbl_we, bus.tbl_addr} !== {2'b10, qidx}) begin
                            miscompares++;
                            $display("FAIL query_read: got en=%b we=%b addr=%0d want 1/0 addr=%0d",
                                     bus.tbl_en, bus.tbl_we, bus.tbl_addr, qidx);
                        end
                        pend_pred = 1'b1;
                        pend_val  = ref_tbl[qidx][1];
                    end else if (bus.tbl_en !== 1'b0) begin
                        miscompares++;
                        $display("FAIL idle_port: got tbl_en=%b want 0", bus.tbl_en);
                    end
                end
                if (bus.upd_en && !full_b) begin
                    e.idx   = bus.upd_pc[IDX_WIDTH+1:2];
                    e.taken = bus.upd_taken;
                    upd_q.push_back(e);
                end
            end
        end
    endtask

    task automatic set_in(logic qen, logic [31:0] qpc, logic uen, logic [31:0] upc, logic ut, logic rdy);
        bus.query_en  = qen;
        bus.query_pc  = qpc;
        bus.upd_en    = uen;
        bus.upd_pc    = upc;
        bus.upd_taken = ut;
        rdy_in        = rdy;
        #1;
    endtask

    task automatic tick();
        observe();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic idle();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
    endtask

    // Writes a table entry through the RAM load port while the scheduler is held in reset.
    task automatic load(int idx, logic [1:0] val);
        rst_in = 1'b1;
        ld_en  = 1'b1;
        ld_idx = IDX_WIDTH'(idx);
        ld_val = val;
        ref_tbl[idx] = val;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        ld_en  = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom), 1'b1);
            vectors++;
            if ({bus.upd_full, bus.query_ready, bus.data_out_en, bus.tbl_en, bus.tbl_addr} !== '0) begin
                miscompares++;
                $display("FAIL test_reset: outputs %b want zero",
                         {bus.upd_full, bus.query_ready, bus.data_out_en, bus.tbl_en, bus.tbl_addr});
            end
            tick();
        end
        for (int i = 0; i < int'(TBL_N); i++) load(i, 2'($urandom_range(0, 3)));
        rst_in = 1'b0;
    endtask

    task automatic test_query_basic();
        load(5, 2'd2);
        rst_in = 1'b0;
        set_in(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if ({bus.query_ready, bus.tbl_en, bus.tbl_we, bus.tbl_addr} !== {3'b110, 6'd5}) begin
            miscompares++;
            $display("FAIL query_basic_issue: got %b want %b",
                     {bus.query_ready, bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {3'b110, 6'd5});
        end
        tick();
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if ({bus.data_out_en, bus.data_out} !== 2'b11) begin
            miscompares++;
            $display("FAIL query_basic_result: got %b want 11", {bus.data_out_en, bus.data_out});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] vals [3];
        vals[0] = 2'd3; vals[1] = 2'd0; vals[2] = 2'd2;
        for (int i = 0; i < 3; i++) load(i, vals[i]);
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_in(1'b1, 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b1);
            else       set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            if (i > 0) begin
                vectors++;
                if ({bus.data_out_en, bus.data_out} !== {1'b1, vals[i-1][1]}) begin
                    miscompares++;
                    $display("FAIL back_to_back_pred%0d: got %b want %b", i - 1,
                             {bus.data_out_en, bus.data_out}, {1'b1, vals[i-1][1]});
                end
            end
            if (i < 3) begin
                vectors++;
                if (bus.tbl_addr !== IDX_WIDTH'(i)) begin
                    miscompares++;
                    $display("FAIL back_to_back_addr%0d: got %0d want %0d", i, bus.tbl_addr, i);
                end
            end
            tick();
        end
    endtask

    task automatic test_update_sat();
        int         idxs [3];
        logic [1:0] init [3];
        logic       tk   [3];
        logic [1:0] want [3];
        idxs[0] = 3; init[0] = 2'd3; tk[0] = 1'b1; want[0] = 2'd3;
        idxs[1] = 7; init[1] = 2'd0; tk[1] = 1'b0; want[1] = 2'd0;
        idxs[2] = 9; init[2] = 2'd1; tk[2] = 1'b1; want[2] = 2'd2;
        for (int k = 0; k < 3; k++) begin
            load(idxs[k], init[k]);
            rst_in = 1'b0;
            set_in(1'b0, 32'h0, 1'b1, 32'(idxs[k] * 4), tk[k], 1'b1);
            tick();
            set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            vectors++;
            if ({bus.tbl_en, bus.tbl_we, bus.tbl_addr} !== {2'b10, IDX_WIDTH'(idxs[k])}) begin
                miscompares++;
                $display("FAIL update_sat_read%0d: got %b want %b", k,
                         {bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {2'b10, IDX_WIDTH'(idxs[k])});
            end
            tick();
            set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            vectors++;
            if ({bus.tbl_en, bus.tbl_we, bus.tbl_addr, bus.tbl_wdata} !==
                {2'b11, IDX_WIDTH'(idxs[k]), want[k]}) begin
                miscompares++;
                $display("FAIL update_sat_write%0d: got addr=%0d wd=%0d want addr=%0d wd=%0d", k,
                         bus.tbl_addr, bus.tbl_wdata, idxs[k], want[k]);
            end
            tick();
            idle();
        end
    endtask

    task automatic test_full_backpressure();
        bit drained;
        load(5, 2'd1);
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'h14, 1'b1, 32'((20 + i) * 4), 1'(i), 1'b1);
            tick();
        end
        set_in(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if ({bus.upd_full, bus.query_ready, bus.tbl_en, bus.tbl_we, bus.tbl_addr} !== {4'b1010, 6'd20}) begin
            miscompares++;
            $display("FAIL full_drain_read: got %b want %b",
                     {bus.upd_full, bus.query_ready, bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {4'b1010, 6'd20});
        end
        tick();
        set_in(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if ({bus.upd_full, bus.query_ready, bus.tbl_we} !== 3'b101) begin
            miscompares++;
            $display("FAIL full_drain_write: got %b want 101", {bus.upd_full, bus.query_ready, bus.tbl_we});
        end
        tick();
        set_in(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if ({bus.upd_full, bus.query_ready, bus.tbl_en, bus.tbl_we, bus.tbl_addr} !== {4'b0110, 6'd5}) begin
            miscompares++;
            $display("FAIL full_resume: got %b want %b",
                     {bus.upd_full, bus.query_ready, bus.tbl_en, bus.tbl_we, bus.tbl_addr}, {4'b0110, 6'd5});
        end
        tick();
        drained = 1'b0;
        for (int i = 0; i < 20 && !drained; i++) begin
            idle();
            drained = (upd_q.size() == 0) && !in_urd && !pend_pred;
        end
        vectors++;
        if (!drained) begin
            miscompares++;
            $display("FAIL full_drain_timeout: %0d updates left want 0", upd_q.size());
        end
    endtask

    task automatic test_wrap();
        int   left;
        int   next_idx;
        int   w0;
        logic uen;
        load(10, 2'd2);
        rst_in = 1'b0;
        w0 = writes_seen;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h28, 1'b1, 32'((30 + i) * 4), 1'($urandom), 1'b1);
            tick();
        end
        left = 6;
        next_idx = 33;
        for (int c = 0; c < 60 && (upd_q.size() != 0 || in_urd || left > 0); c++) begin
            uen = in_urd && (left > 0);
            set_in(1'b0, 32'h0, uen, 32'(next_idx * 4), 1'($urandom), 1'b1);
            if (uen) begin
                vectors++;
                if (bus.upd_full !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wrap_push_pop_full: got %b want 0", bus.upd_full);
                end
            end
            tick();
            if (uen) begin
                left--;
                next_idx++;
            end
        end
        vectors++;
        if (writes_seen - w0 !== 9) begin
            miscompares++;
            $display("FAIL wrap_write_count: got %0d want 9", writes_seen - w0);
        end
    endtask

    task automatic test_rdy_pause();
        load(6, 2'd2);
        rst_in = 1'b0;
        set_in(1'b1, 32'h18, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h18, 1'b1, 32'h40, 1'b1, 1'b0);
            vectors++;
            if ({bus.tbl_en, bus.query_ready, bus.data_out_en} !== 3'b000) begin
                miscompares++;
                $display("FAIL rdy_pause%0d: got %b want 000", i,
                         {bus.tbl_en, bus.query_ready, bus.data_out_en});
            end
            tick();
        end
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if ({bus.data_out_en, bus.data_out, bus.tbl_en} !== 3'b110) begin
            miscompares++;
            $display("FAIL rdy_resume: got %b want 110", {bus.data_out_en, bus.data_out, bus.tbl_en});
        end
        tick();
    endtask

    task automatic test_reset_mid_update();
        load(8, 2'd1);
        rst_in = 1'b0;
        set_in(1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 1'b1, 32'h24, 1'b1, 1'b1);
        tick();
        rst_in = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if ({bus.tbl_en, bus.tbl_we, bus.upd_full, bus.query_ready} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_update: got %b want 0000",
                     {bus.tbl_en, bus.tbl_we, bus.upd_full, bus.query_ready});
        end
        tick();
        rst_in = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if ({bus.tbl_en, bus.upd_full} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_fifo_empty: got %b want 00", {bus.tbl_en, bus.upd_full});
        end
        tick();
        vectors++;
        if (mem[8] !== 2'd1) begin
            miscompares++;
            $display("FAIL reset_no_write: table[8]=%0d want 1", mem[8]);
        end
    endtask

    task automatic test_random();
        logic [31:0] qpc;
        logic [31:0] upc;
        bit          drained;
        for (int c = 0; c < 3000; c++) begin
            qpc = $urandom;
            upc = $urandom;
            qpc[IDX_WIDTH+1:2] = IDX_WIDTH'($urandom_range(0, 7));
            upc[IDX_WIDTH+1:2] = IDX_WIDTH'($urandom_range(0, 7));
            set_in(1'($urandom_range(0, 9) < 6), qpc, 1'($urandom_range(0, 9) < 4), upc,
                   1'($urandom), 1'($urandom_range(0, 9) != 0));
            tick();
        end
        drained = 1'b0;
        for (int i = 0; i < 40 && !drained; i++) begin
            idle();
            drained = (upd_q.size() == 0) && !in_urd && !pend_pred;
        end
        vectors++;
        if (!drained) begin
            miscompares++;
            $display("FAIL random_drain_timeout: %0d updates left want 0", upd_q.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        bus.query_en = 1'b0; bus.query_pc = '0;
        bus.upd_en = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
        @(negedge clk_in);
        test_reset();
        test_query_basic();
        test_back_to_back();
        test_update_sat();
        test_full_backpressure();
        test_wrap();
        test_rdy_pause();
        test_reset_mid_update();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
